// File: rtl/aes_inv_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_inv_round_ctrl
//   Iterative AES-128 decryption round sequencer. One ciphertext block is
//   loaded into a single 128-bit state register and run through the inverse
//   cipher one round per clock: initial AddRoundKey, NR-1 full inverse rounds,
//   then the final round (no InvMixColumns). Round keys are fetched by index
//   from an external expanded-key store that answers combinationally.
//
//   Byte order everywhere: byte i of the AES state sits at bits
//   [127-8*i -: 8], row = i % 4, column = i / 4. This makes a FIPS-197 hex
//   string read left-to-right map directly onto the 128-bit vector.
//
// Optional feature macro: AES_DEC_ABORT_EN
//   defined   -> an 'abort' input exists; it flushes the sequencer back to
//                IDLE on the next edge (state register is left as is).
//   undefined -> no abort port; only rst abandons a block.
//
// Ports (aes_inv_round_ctrl):
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous active-high reset
//   in_valid   in   1    ciphertext offered
//   in_ready   out  1    high only in IDLE (decoded from the FSM state alone)
//   in_data    in   128  ciphertext
//   rk_idx     out  4    round-key index; names the key used this cycle
//   rk_data    in   128  round key for rk_idx, valid in the same cycle
//   out_valid  out  1    plaintext available, held until out_ready
//   out_ready  in   1    consumer takes the plaintext
//   out_data   out  128  plaintext (the state register itself)
//   abort      in   1    synchronous flush (AES_DEC_ABORT_EN only)
//   busy       out  1    high in every state except IDLE
//
// Parameter NR: number of cipher rounds, legal range 2..15 (rk_idx is 4 bits).
// -----------------------------------------------------------------------------

// InvShiftRows: row r is rotated right by r columns.
// Ports: din (128) state in, dout (128) state out.
module inv_shift_rows (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = ((COL - ROW + 4) % 4) * 4 + ROW;
    assign dout[127-8*gi -: 8] = din[127-8*SRC -: 8];
  end
endmodule

// InvSubBytes: inverse S-box on all 16 bytes.
// Ports: din (128) state in, dout (128) state out.
// The inverse S-box is built arithmetically: undo the affine map, then take
// the multiplicative inverse in GF(2^8) as x^254 (0 maps to 0 for free).
module inv_sub_bytes (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] x, x2, x3, x6, x12, x14, x15, x30, x60, x120, x240;
    // inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
    x    = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    return gf_mul(x240, x14);
  endfunction

  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    assign dout[127-8*gi -: 8] = inv_sbox(din[127-8*gi -: 8]);
  end
endmodule

// InvMixColumns: each column multiplied by the {0e,0b,0d,09} circulant.
// Ports: din (128) state in, dout (128) state out.
module inv_mix_columns (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = din[127-32*gi -: 8];
    assign a1 = din[119-32*gi -: 8];
    assign a2 = din[111-32*gi -: 8];
    assign a3 = din[103-32*gi -: 8];
    assign dout[127-32*gi -: 8] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
    assign dout[119-32*gi -: 8] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
    assign dout[111-32*gi -: 8] = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
    assign dout[103-32*gi -: 8] = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
  end
endmodule

module aes_inv_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
`ifdef AES_DEC_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy
);

  localparam logic [3:0] NR_IDX = 4'(NR);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ROUND,
    FINAL,
    DONE
  } fsm_t;

  fsm_t         fsm_reg;
  logic [127:0] state_reg;
  logic [3:0]   rk_idx_reg;
  logic         out_valid_reg;

  logic         abort_req;

`ifdef AES_DEC_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Datapath: shift -> sub -> key add -> mix. FINAL taps the key-add result,
  // ROUND takes the mixed result.
  logic [127:0] shift_out;
  logic [127:0] sub_out;
  logic [127:0] ark_out;
  logic [127:0] mix_out;

  inv_shift_rows u_inv_shift_rows (
    .din  (state_reg),
    .dout (shift_out)
  );

  inv_sub_bytes u_inv_sub_bytes (
    .din  (shift_out),
    .dout (sub_out)
  );

  assign ark_out = sub_out ^ rk_data;

  inv_mix_columns u_inv_mix_columns (
    .din  (ark_out),
    .dout (mix_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_reg       <= IDLE;
      state_reg     <= '0;
      rk_idx_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else if (abort_req) begin
      // Flush wins over acceptance and handoff. In IDLE it simply suppresses
      // acceptance for that cycle. The state register keeps its contents.
      if (fsm_reg != IDLE) begin
        fsm_reg       <= IDLE;
        rk_idx_reg    <= '0;
        out_valid_reg <= 1'b0;
      end
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg  <= in_data;
            rk_idx_reg <= NR_IDX;
            fsm_reg    <= INIT;
          end
        end
        INIT: begin
          state_reg  <= state_reg ^ rk_data;
          rk_idx_reg <= NR_IDX - 4'd1;
          fsm_reg    <= ROUND;
        end
        ROUND: begin
          state_reg <= mix_out;
          if (rk_idx_reg == 4'd1) begin
            rk_idx_reg <= 4'd0;
            fsm_reg    <= FINAL;
          end else begin
            rk_idx_reg <= rk_idx_reg - 4'd1;
          end
        end
        FINAL: begin
          state_reg     <= ark_out;
          out_valid_reg <= 1'b1;
          fsm_reg       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            fsm_reg       <= IDLE;
          end
        end
        default: begin
          fsm_reg       <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (fsm_reg == IDLE);
  assign busy      = (fsm_reg != IDLE);
  assign rk_idx    = rk_idx_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = state_reg;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
module tb_aes_inv_round_ctrl;

  localparam int NR = 10;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KEY0 = 128'h0;
  localparam logic [127:0] PT0  = 128'h0;
  localparam logic [127:0] CT0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;
`ifdef AES_DEC_ABORT_EN
  logic         abort = 1'b0;
`endif

  aes_inv_round_ctrl #(.NR(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef AES_DEC_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Key store: combinational lookup by index.
  logic [127:0] rk_mem [0:15];
  assign rk_data = rk_mem[rk_idx];

  typedef struct {
    logic [127:0] data;
    int           acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   last_acc = 0;
  logic [7:0] sbox [0:255];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name, input int n);
    checks++;
    errors++;
    $display("FAIL %s: no response within %0d cycles", name, n);
  endtask

  // ---------------- reference model: forward AES-128 ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int r = 11; r < 16; r++) rk_mem[r] = rand128();
  endtask

  // Encrypts with the key schedule currently in rk_mem.
  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rk_mem[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
      s = t;
      for (int i = 0; i < 16; i++)
        t[127-8*i -: 8] = s[127-8*((((i/4) + (i%4)) % 4)*4 + (i%4)) -: 8];
      s = t;
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8];
          a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8];
          a3 = s[103-32*c -: 8];
          t[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          t[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          t[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          t[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        s = t;
      end
      s = s ^ rk_mem[r];
    end
    return s;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called just after a falling edge. Loads the key store while the DUT is
  // idle, then lets the acceptance edge pass and records it.
  task automatic send(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt);
    exp_t e;
    int   n = 0;
    in_data  = ct;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      timeout_fail("accept", n);
    end else begin
      load_key(key);
      e.data    = pt;
      e.acc_cyc = cyc + 1;
      exp_q.push_back(e);
      last_acc  = cyc + 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = rand128();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) timeout_fail("wait_idle", n);
  endtask

  task automatic wait_rk(input logic [3:0] idx);
    int n = 0;
    while (rk_idx !== idx && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("reach_rk_idx", 128'(rk_idx), 128'(idx));
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", 128'(out_valid), 128'(1));
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    exp_t cur;
    logic prev_valid;
    cur.data    = '0;
    cur.acc_cyc = 0;
    prev_valid  = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out_valid: got out_data %h with no block outstanding", out_data);
          end else begin
            cur = exp_q.pop_front();
            check("plaintext", out_data, cur.data);
            check("latency", 128'(cyc - cur.acc_cyc), 128'(NR + 1));
          end
        end else begin
          check("hold_stable", out_data, cur.data);
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin : stim
    logic [127:0] k, p, c;
    int first_acc;
    int n;
    bit done;

    for (int r = 0; r < 16; r++) rk_mem[r] = '0;
    build_sbox();

    // Reference model sanity against FIPS-197 constants.
    load_key(KEY1);
    check("model_rk10", rk_mem[10], RK10);
    check("model_c1", encrypt(PT1), CT1);
    load_key(KEY0);
    check("model_zero_key", encrypt(PT0), CT0);

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_rk_idx", 128'(rk_idx), 128'(0));
    check("reset_out_data", out_data, 128'h0);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 C.1 with rk_idx walk.
    out_ready = 1'b1;
    send(KEY1, CT1, PT1);
    for (int j = 0; j <= NR; j++) begin
      check("rk_idx_seq", 128'(rk_idx), 128'(NR - j));
      check("busy_running", 128'(busy), 128'(1));
      check("in_ready_running", 128'(in_ready), 128'(0));
      @(negedge clk);
    end
    wait_idle();

    // Backpressure: 20 stalled cycles, stray in_valid ignored.
    out_ready = 1'b0;
    k = rand128();
    p = rand128();
    load_key(k);
    c = encrypt(p);
    send(k, c, p);
    wait_out_valid();
    for (int j = 0; j < 20; j++) begin
      in_valid = 1'b1;
      in_data  = rand128();
      check("bp_in_ready_low", 128'(in_ready), 128'(0));
      check("bp_valid_held", 128'(out_valid), 128'(1));
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 128'(in_ready), 128'(1));
    check("bp_release_valid", 128'(out_valid), 128'(0));
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_no_capture", 128'(busy), 128'(0));

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1;
    send(KEY1, CT1, PT1);
    first_acc = last_acc;
    send(KEY0, CT0, PT0);
    check("b2b_interval", 128'(last_acc - first_acc), 128'(NR + 3));
    wait_idle();

    // Asynchronous reset in the middle of round processing.
    send(KEY1, CT1, PT1);
    wait_rk(4'd5);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 128'(out_valid), 128'(0));
    check("async_rst_busy", 128'(busy), 128'(0));
    check("async_rst_in_ready", 128'(in_ready), 128'(1));
    check("async_rst_rk_idx", 128'(rk_idx), 128'(0));
    check("async_rst_out_data", out_data, 128'h0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    send(KEY1, CT1, PT1);
    wait_idle();

    // Random keys and plaintexts with random consumer stalls.
    for (int i = 0; i < 20; i++) begin
      k = rand128();
      p = rand128();
      load_key(k);
      c = encrypt(p);
      out_ready = 1'($urandom_range(0, 1));
      send(k, c, p);
      n = 0;
      done = 1'b0;
      while (!done && n < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid === 1'b1 && out_ready) done = 1'b1;
        @(negedge clk);
        n++;
      end
      if (!done) timeout_fail("random_handoff", n);
      out_ready = 1'b0;
    end

`ifdef AES_DEC_ABORT_EN
    // Abort mid-block.
    out_ready = 1'b1;
    send(KEY1, CT1, PT1);
    wait_rk(4'd4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_rk_idx", 128'(rk_idx), 128'(0));
    check("abort_out_valid", 128'(out_valid), 128'(0));
    exp_q.delete();
    repeat (15) @(negedge clk);

    // Abort together with out_ready in DONE.
    out_ready = 1'b0;
    send(KEY1, CT1, PT1);
    wait_out_valid();
    abort     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    out_ready = 1'b0;
    check("abort_done_valid", 128'(out_valid), 128'(0));
    check("abort_done_busy", 128'(busy), 128'(0));

    // Abort in IDLE blocks acceptance.
    in_valid = 1'b1;
    in_data  = CT1;
    abort    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    abort    = 1'b0;
    check("abort_idle_no_accept", 128'(busy), 128'(0));
    repeat (5) @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_round_ctrl.md
# aes_inv_round_ctrl

Iterative AES-128 decryption round sequencer. It accepts one 128-bit ciphertext block and walks the inverse-cipher round sequence one round per clock: initial AddRoundKey, NR-1 full inverse rounds, then the final round. It instantiates the combinational inv_shift_rows, inv_sub_bytes and inv_mix_columns datapath blocks around a single 128-bit state register. Round keys are fetched by index from the external expanded-key store.

## Interface
- NR, 10, number of cipher rounds; legal range 2..15, and rk_idx is 4 bits wide.
- clk  input  1  rising-edge clock, the only clock in the block.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a ciphertext block is offered.
- in_ready  output  1  the block can accept a ciphertext; high only in IDLE.
- in_data  input  128  ciphertext, in the same byte order as the datapath blocks.
- rk_idx  output  4  round-key index presented to the key store.
- rk_data  input  128  round key for rk_idx; combinational and valid in the same cycle.
- out_valid  output  1  plaintext is available.
- out_ready  input  1  the consumer takes the plaintext.
- out_data  output  128  plaintext; this is the state register.
- busy  output  1  high in every state except IDLE.
- abort  input  1  synchronous flush. This port exists only under AES_DEC_ABORT_EN.

## Operation
- FSM states: IDLE, INIT, ROUND, FINAL, DONE.
- IDLE
  - in_ready=1.
  - On in_valid: state<=in_data, rk_idx<=NR, go to INIT.
- INIT
  - state<=state^rk_data.
  - rk_idx<=NR-1, go to ROUND.
- ROUND
  - state<=inv_mix_columns(inv_sub_bytes(inv_shift_rows(state))^rk_data).
  - If rk_idx==1: rk_idx<=0 and go to FINAL. Otherwise rk_idx<=rk_idx-1.
- FINAL
  - state<=inv_sub_bytes(inv_shift_rows(state))^rk_data.
  - out_valid<=1, go to DONE.
- DONE
  - out_valid=1. out_data is held stable until out_ready.
  - On out_ready: out_valid<=0, go to IDLE.
- rk_idx is a registered output. It always equals the index of the key consumed in the current cycle.
- in_ready is combinational from the FSM state only. It never depends on in_valid.
- Reset: FSM=IDLE, state=0, rk_idx=0, out_valid=0, busy=0, in_ready=1.
- Reset asserted mid-operation discards the block. No partial output is ever flagged valid.
- in_valid while busy is ignored and in_data is not sampled.
- out_ready outside DONE is ignored.

## Timing
- Latency: the acceptance edge is E0, and out_valid rises after edge E(NR+1). That is 11 cycles for NR=10.
- Edge breakdown: E1=INIT, E2..E(NR)=ROUND (NR-1 edges), E(NR+1)=FINAL.
- Handoff: the out_valid&out_ready edge returns the FSM to IDLE. The next acceptance occurs no earlier than the following edge.
- Minimum block-to-block interval is NR+3 cycles with out_ready held high.
- Critical path: state -> shift -> sub -> XOR -> mix -> state, plus rk_data arrival. The key store must meet rk_data within one cycle of rk_idx.

## Configuration
- AES_DEC_ABORT_EN defined:
  - The abort port exists.
  - abort=1 in any state other than IDLE sets, on the next edge: FSM=IDLE, out_valid=0, rk_idx=0. state is not cleared.
  - abort has priority over out_ready and over acceptance in the same cycle.
  - abort in IDLE blocks acceptance that cycle.
- AES_DEC_ABORT_EN undefined:
  - No abort port exists.
  - The only way to abandon a block is rst.

## Test plan
- FIPS-197 C.1 vector:
  - Stimulus: key store loaded with the expansion of 000102030405060708090a0b0c0d0e0f (rk[10]=13111d7fe3944a17f307a78b4d2b30c5); in_data=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: out_data=00112233445566778899aabbccddeeff with out_valid exactly 11 cycles after acceptance.
  - rk_idx sequence must read 10,9,...,1,0 on consecutive cycles.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0, and a new in_valid is ignored. Release -> IDLE next cycle.
- Back-to-back: two blocks (C.1 ciphertext, then the all-zero-key vector 66e94bd4ef8a2c3b884cfa59ca342b2e) with in_valid and out_ready held high -> 00112233445566778899aabbccddeeff then 00000000000000000000000000000000. The second acceptance occurs 13 cycles after the first.
- Reset mid-operation: assert rst asynchronously at round 5 -> all outputs return to reset values immediately. No out_valid follows. The next block decrypts correctly.
- Abort (AES_DEC_ABORT_EN): pulse abort at rk_idx=4 -> IDLE next edge, out_valid never rises. abort together with out_ready in DONE -> out_valid drops and no double handoff occurs.
